// File: rtl/sort_scheduler_pkg.sv
// Shared types and defaults for the sort_scheduler block.
// The FSM state encoding is fixed so waveforms read the same across builds.
package sort_scheduler_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_DEPTH = 8;

endpackage

// File: rtl/sort_scheduler_if.sv
// Operand-in / result-out valid/ready streams for sort_scheduler.
// master = producer+consumer side, slave = the scheduler.
interface sort_scheduler_if
  import sort_scheduler_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/sort_scheduler_comparator.sv
// Existing combinational magnitude comparator shared by the sort sequencer.
// Exactly one of Greater/Equal/Less is high for any A/B pair.
module Comparator
  import sort_scheduler_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  output logic             Greater,
  output logic             Equal,
  output logic             Less,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B
);

  assign Greater = (A > B);
  assign Equal   = (A == B);
  assign Less    = (A < B);

endmodule

// File: rtl/sort_scheduler.sv
// In-place bubble sort of a small operand buffer using one shared Comparator.
// Define SORT_SCHEDULER_DESCEND_EN to swap on Less (descending, still stable).
module sort_scheduler
  import sort_scheduler_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  sort_scheduler_if.slave bus,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] count
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t           state_reg, state_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [IW-1:0]    idx_reg, idx_next;
  logic [IW-1:0]    last_reg, last_next;
  logic             swapped_reg, swapped_next;
  logic             done_reg, done_next;

  logic [WIDTH-1:0] buf_mem [DEPTH];
  logic [WIDTH-1:0] cmp_a, cmp_b;
  logic             gt, eq, lt;
  logic             do_swap, in_fire, out_fire;
  logic [IW-1:0]    idx_p1;
  logic [CW-1:0]    count_eff;

  assign idx_p1    = idx_reg + IW'(1);
  assign cmp_a     = buf_mem[idx_reg];
  assign cmp_b     = buf_mem[idx_p1];

  Comparator #(.WIDTH(WIDTH)) u_cmp (
    .Greater (gt),
    .Equal   (eq),
    .Less    (lt),
    .A       (cmp_a),
    .B       (cmp_b)
  );

  // Only a clean one-hot comparator verdict may trigger a swap.
`ifdef SORT_SCHEDULER_DESCEND_EN
  assign do_swap = (state_reg == SORT) && lt && !eq && !gt;
`else
  assign do_swap = (state_reg == SORT) && gt && !eq && !lt;
`endif

  assign bus.in_ready  = (state_reg == LOAD) && (count_reg != CW'(DEPTH));
  assign in_fire       = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state_reg == DRAIN);
  assign bus.out_data  = (state_reg == DRAIN) ? buf_mem[idx_reg] : '0;
  assign out_fire      = bus.out_valid && bus.out_ready;
  assign count_eff     = count_reg + CW'(in_fire);

  assign busy  = (state_reg != LOAD);
  assign done  = done_reg;
  assign count = count_reg;

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    idx_next     = idx_reg;
    last_next    = last_reg;
    swapped_next = swapped_reg;
    done_next    = 1'b0;
    case (state_reg)
      LOAD: begin
        count_next = count_eff;
        if (start) begin
          if (count_eff == '0) begin
            done_next = 1'b1;
          end else if (count_eff == CW'(1)) begin
            state_next = DRAIN;
            idx_next   = '0;
          end else begin
            state_next   = SORT;
            idx_next     = '0;
            swapped_next = 1'b0;
            last_next    = IW'(count_eff - CW'(2));
          end
        end
      end
      SORT: begin
        // The swap made on the last pair still counts toward this pass.
        if (idx_reg != last_reg) begin
          idx_next     = idx_p1;
          swapped_next = swapped_reg | do_swap;
        end else if (!(swapped_reg | do_swap) || (last_reg == '0)) begin
          state_next = DRAIN;
          idx_next   = '0;
        end else begin
          last_next    = last_reg - IW'(1);
          idx_next     = '0;
          swapped_next = 1'b0;
        end
      end
      DRAIN: begin
        if (out_fire) begin
          if (idx_reg == IW'(count_reg - CW'(1))) begin
            state_next = LOAD;
            count_next = '0;
            idx_next   = '0;
            done_next  = 1'b1;
          end else begin
            idx_next = idx_p1;
          end
        end
      end
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= LOAD;
      count_reg   <= '0;
      idx_reg     <= '0;
      last_reg    <= '0;
      swapped_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      idx_reg     <= idx_next;
      last_reg    <= last_next;
      swapped_reg <= swapped_next;
      done_reg    <= done_next;
    end
  end

  // Each entry is written by a load or by either side of a swap; contents need no reset.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (in_fire && (count_reg[IW-1:0] == IW'(gi))) begin
        buf_mem[gi] <= bus.in_data;
      end else if (do_swap && (idx_reg == IW'(gi))) begin
        buf_mem[gi] <= cmp_b;
      end else if (do_swap && (idx_p1 == IW'(gi))) begin
        buf_mem[gi] <= cmp_a;
      end
    end
  end

endmodule

// File: doc/sort_scheduler.md
Name: sort_scheduler

Overview:
- Sequencer that shares one 4-bit magnitude comparator (the existing `Comparator` module) to sort a small buffer of operands.
- Operands stream in over a valid/ready handshake and are bubble-sorted in place, one compare per cycle. Results stream out ascending over a valid/ready handshake.
- Sits between an operand producer and a consumer; this is the first sequential user of the comparator datapath.

Parameters:
- WIDTH, 4, operand width; must match the comparator's operand width.
- DEPTH, 8, buffer entries; 2..16.
- CW, $clog2(DEPTH+1), width of the count field.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  producer has an operand.
- in_ready  out  1  block accepts an operand (LOAD state and buffer not full).
- in_data  in  WIDTH  operand.
- start  in  1  begin sorting the loaded operands; sampled in LOAD only.
- busy  out  1  high in SORT and DRAIN.
- done  out  1  one-cycle pulse when the last result is accepted, or when start is seen with an empty buffer.
- out_valid  out  1  result available (DRAIN only).
- out_ready  in  1  consumer accepts a result.
- out_data  out  WIDTH  current result.
- count  out  CW  number of operands held.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n low at a clock edge):
  - State goes to LOAD; count=0; index=0.
  - in_ready=1, busy=0, done=0, out_valid=0, out_data=0.
  - Buffer contents are don't-care.
  - Reset mid-SORT or mid-DRAIN aborts and discards all data; no done pulse.
- LOAD:
  - Handshake fires when in_valid && in_ready: buf[count] <= in_data; count++.
  - in_ready=0 when count==DEPTH. in_valid while full is ignored and not lost-counted.
- start in LOAD:
  - If a handshake fires in the same cycle, that operand is included.
  - Effective count 0: done pulses next cycle; stay in LOAD.
  - Effective count 1: go to DRAIN.
  - Otherwise go to SORT with idx=0, swapped=0, last=count-2.
- SORT (in_ready=0, busy=1):
  - Each cycle the comparator sees A=buf[idx], B=buf[idx+1].
  - If Greater: swap the two entries in the same cycle and set swapped=1. Equal and Less leave both entries unchanged (the sort is stable).
  - If idx<last: idx++.
  - At idx==last (end of pass):
    - If swapped==0 or last==0: go to DRAIN with idx=0.
    - Else: last--, idx=0, swapped=0.
  - Cost: a pass over n entries takes n-1 cycles. Worst case is n(n-1)/2 cycles; a presorted buffer completes in n-1 cycles.
- DRAIN:
  - out_valid=1 and out_data=buf[idx] (registered, stable while stalled).
  - On out_valid && out_ready: idx++.
  - On the final transfer: count=0, done pulses next cycle, return to LOAD.
  - out_ready low holds out_data unchanged.
- start outside LOAD is ignored. in_valid outside LOAD is not accepted.

Optional Feature:
- Macro: SORT_SCHEDULER_DESCEND_EN.
- Defined: the swap condition becomes Less; output order is descending, still stable.
- Undefined: swap on Greater; output ascending.
- Port list and timing are identical either way.

Decomposition:
- Package sort_scheduler_pkg holds:
  - state enum: LOAD=2'd0, SORT=2'd1, DRAIN=2'd2.
  - default WIDTH and DEPTH constants.
- One sub-module: the existing `Comparator` instantiated once, port order (Greater, Equal, Less, A, B). No other comparison logic in the block.
- Buffer, index and pass counters stay inline.

Test Plan:
- Load 9,5,12,4,0 then start → out 0,4,5,9,12; done pulses once; busy low afterwards.
- Load 8 operands 1..8 already ascending, then start → SORT lasts exactly 7 cycles; outputs 1..8.
- Load 15,0,15,0 then toggle out_ready 1/0 each cycle → 0,0,15,15; out_data stable while stalled; no duplicates or drops.
- Load 8 operands, keep in_valid high with a 9th value 3 → in_ready=0, count stays 8, 3 never appears at the output.
- start with empty buffer → done pulse one cycle later, no out_valid. Also: start in the same cycle as an accepted 6 with count 0 → single output 6.
- Assert rst_n low mid-SORT on 7,2,9 → next cycle count=0, in_ready=1, out_valid=0. Reloading 3,1 → outputs 1,3.
- With SORT_SCHEDULER_DESCEND_EN defined, load 9,5,12,4 → outputs 12,9,5,4.
